// File: rtl/ifu_itcm_rsp_if.sv
// ----------------------------------------------------------------------------
// ifu_itcm_rsp_if
// Groups the IFU fetch channel (request and response) and the program-load
// side port between the fetch unit and the ITCM responder.
//   master : IFU / loader side. It drives req_valid/req_pc, rsp_ready and load_*.
//   slave  : ITCM responder. It drives req_ready, rsp_valid/instr/err and load_ready.
// ----------------------------------------------------------------------------
interface ifu_itcm_rsp_if #(
    parameter int PC_SIZE    = 32,
    parameter int INSTR_SIZE = 32,
    parameter int ITCM_AW    = 12
);
    logic                  ifu_req_valid;
    logic                  ifu_req_ready;
    logic [PC_SIZE-1:0]    ifu_req_pc;
    logic                  ifu_rsp_valid;
    logic                  ifu_rsp_ready;
    logic [INSTR_SIZE-1:0] ifu_rsp_instr;
    logic                  ifu_rsp_err;
    logic                  load_valid;
    logic                  load_ready;
    logic [ITCM_AW-1:0]    load_addr;
    logic [INSTR_SIZE-1:0] load_data;

    modport master (
        output ifu_req_valid, ifu_req_pc, ifu_rsp_ready,
               load_valid, load_addr, load_data,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, ifu_rsp_err,
               load_ready
    );

    modport slave (
        input  ifu_req_valid, ifu_req_pc, ifu_rsp_ready,
               load_valid, load_addr, load_data,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, ifu_rsp_err,
               load_ready
    );
endinterface

// File: rtl/ifu_itcm_rsp.sv
// ----------------------------------------------------------------------------
// ifu_itcm_rsp
// Responder end of the IFU fetch interface, backed by a word-addressed ITCM
// with a one-cycle synchronous read. Each accepted PC produces exactly one
// {err, instr} response, in order. If the response FIFO is empty, the
// response comes straight from the read port one cycle after the handshake.
// Otherwise the response queues behind older entries in a small FIFO. A side
// load port writes program words and takes priority over fetch.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   io_bus     : ifu_itcm_rsp_if.slave (fetch request/response and load port)
// ----------------------------------------------------------------------------
module ifu_itcm_rsp #(
    parameter int                   PC_SIZE    = 32,
    parameter int                   INSTR_SIZE = 32,
    parameter int                   ITCM_AW    = 12,
    parameter logic [PC_SIZE-1:0]   ITCM_BASE  = 32'h8000_0000,
    parameter int                   RSP_DEPTH  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    ifu_itcm_rsp_if.slave       io_bus
);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int WORDS = 2 ** ITCM_AW;
    localparam logic [INSTR_SIZE-1:0] NOP_INSTR = INSTR_SIZE'(32'h0000_0013);

    // The FIFO pointer wraps modulo RSP_DEPTH, so depths that are not a power of two also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(RSP_DEPTH - 1)) begin
            ptr_inc = {PTR_W{1'b0}};
        end else begin
            ptr_inc = p + PTR_W'(1'b1);
        end
    endfunction

    logic [INSTR_SIZE-1:0] r_mem [WORDS];
    logic [INSTR_SIZE-1:0] r_rdata;
    logic                  r_en;
    logic                  r_inflight;
    logic                  r_inflight_err;
    logic [INSTR_SIZE:0]   r_fifo [RSP_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_cnt;

    logic [PC_SIZE-1:0]    w_offset;
    logic                  w_hit;
    logic [ITCM_AW-1:0]    w_rd_idx;
    logic                  w_fifo_empty;
    logic                  w_credit_ok;
    logic                  w_req_ready;
    logic                  w_req_fire;
    logic [INSTR_SIZE-1:0] w_byp_instr;
    logic [INSTR_SIZE:0]   w_head;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_rsp_err;
    logic [INSTR_SIZE-1:0] w_rsp_instr;

    // Decode the request, check credit, and choose between pushing and popping the FIFO.
    always_comb begin
        // Unsigned modulo subtraction, so a PC below the base wraps to a large offset and misses.
        w_offset     = io_bus.ifu_req_pc - ITCM_BASE;
        w_hit        = (w_offset[PC_SIZE-1:ITCM_AW+2] == {(PC_SIZE-ITCM_AW-2){1'b0}})
                       && (w_offset[1:0] == 2'b00);
        w_rd_idx     = w_offset[ITCM_AW+1:2];
        w_fifo_empty = (r_cnt == {CNT_W{1'b0}});
        // Credit counts only what is already committed. A pop in this cycle does not return credit.
        w_credit_ok  = ({1'b0, r_cnt} + (CNT_W+1)'(r_inflight)) < (CNT_W+1)'(RSP_DEPTH);
        w_req_ready  = r_en & ~io_bus.load_valid & w_credit_ok;
        w_req_fire   = io_bus.ifu_req_valid & w_req_ready;
        w_byp_instr  = r_inflight_err ? NOP_INSTR : r_rdata;
        w_head       = r_fifo[r_rd_ptr];
        w_pop        = ~w_fifo_empty & io_bus.ifu_rsp_ready;
        // The in-flight read goes into the FIFO unless it leaves this cycle on the bypass path.
        w_push       = r_inflight & ~(w_fifo_empty & io_bus.ifu_rsp_ready);
    end

    // Response mux: FIFO head first, then the bypass path, else zero.
    always_comb begin
        w_rsp_err   = 1'b0;
        w_rsp_instr = {INSTR_SIZE{1'b0}};
        if (!w_fifo_empty) begin
            w_rsp_err   = w_head[INSTR_SIZE];
            w_rsp_instr = w_head[INSTR_SIZE-1:0];
        end else if (r_inflight) begin
            w_rsp_err   = r_inflight_err;
            w_rsp_instr = w_byp_instr;
        end else begin
            w_rsp_err   = 1'b0;
            w_rsp_instr = {INSTR_SIZE{1'b0}};
        end
    end

    assign io_bus.ifu_req_ready = w_req_ready;
    assign io_bus.load_ready    = r_en;
    assign io_bus.ifu_rsp_valid = ~w_fifo_empty | r_inflight;
    assign io_bus.ifu_rsp_err   = w_rsp_err;
    assign io_bus.ifu_rsp_instr = w_rsp_instr;

    // Control state: enable after reset, in-flight read tracking, FIFO pointers and count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en           <= 1'b0;
            r_inflight     <= 1'b0;
            r_inflight_err <= 1'b0;
            r_wr_ptr       <= {PTR_W{1'b0}};
            r_rd_ptr       <= {PTR_W{1'b0}};
            r_cnt          <= {CNT_W{1'b0}};
        end else begin
            r_en       <= 1'b1;
            r_inflight <= w_req_fire;
            if (w_req_fire) begin
                r_inflight_err <= ~w_hit;
            end
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1'b1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1'b1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // FIFO storage. Output masking makes stale contents invisible, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {r_inflight_err, w_byp_instr};
        end
    end

    // Single-port ITCM. Load and fetch never access it in the same cycle because load blocks req_ready.
    always_ff @(posedge clk) begin
        if (r_en & io_bus.load_valid) begin
            r_mem[io_bus.load_addr] <= io_bus.load_data;
        end
        if (w_req_fire & w_hit) begin
            r_rdata <= r_mem[w_rd_idx];
        end
    end
endmodule

// File: tb/tb_ifu_itcm_rsp.sv
// ----------------------------------------------------------------------------
// tb_ifu_itcm_rsp
// Directed bench for ifu_itcm_rsp, followed by a randomized valid/ready run
// that compares responses against a scoreboard. Inputs change on the falling
// edge, and outputs are sampled on the falling edge or 1ns after it.
// ----------------------------------------------------------------------------
module tb_ifu_itcm_rsp;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ifu_itcm_rsp_if #(.PC_SIZE(32), .INSTR_SIZE(32), .ITCM_AW(12)) bus ();

    ifu_itcm_rsp dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    task automatic load_word(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.load_valid = 1'b1;
        bus.load_addr  = a;
        bus.load_data  = d;
        @(negedge clk);
        bus.load_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.ifu_req_valid = 1'b0;
        bus.ifu_req_pc    = 32'h0;
        bus.ifu_rsp_ready = 1'b0;
        bus.load_valid    = 1'b0;
        bus.load_addr     = 12'h0;
        bus.load_data     = 32'h0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.ifu_req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%b want=0", bus.ifu_req_ready); end
        checks++; if (bus.ifu_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b want=0", bus.ifu_rsp_valid); end
        checks++; if (bus.ifu_rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got=%b want=0", bus.ifu_rsp_err); end
        checks++; if (bus.ifu_rsp_instr !== 32'h0) begin errors++; $display("FAIL reset_rsp_instr got=%h want=00000000", bus.ifu_rsp_instr); end
        checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL reset_load_ready got=%b want=0", bus.load_ready); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.ifu_req_ready !== 1'b0) begin errors++; $display("FAIL release_pre_edge_ready got=%b want=0", bus.ifu_req_ready); end
        @(negedge clk);
        checks++; if (bus.ifu_req_ready !== 1'b1) begin errors++; $display("FAIL release_req_ready got=%b want=1", bus.ifu_req_ready); end
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL release_load_ready got=%b want=1", bus.load_ready); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_w [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        for (int i = 0; i < 4; i++) load_word(12'(i), exp_w[i]);
        load_word(12'hFFF, 32'hA5A5_0FFF);
        bus.ifu_rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++; if (bus.ifu_rsp_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%b want=1", k, bus.ifu_rsp_valid); end
                checks++; if (bus.ifu_rsp_instr !== exp_w[k-1]) begin errors++; $display("FAIL stream_instr[%0d] got=%h want=%h", k, bus.ifu_rsp_instr, exp_w[k-1]); end
                checks++; if (bus.ifu_rsp_err !== 1'b0) begin errors++; $display("FAIL stream_err[%0d] got=%b want=0", k, bus.ifu_rsp_err); end
            end
            if (k < 4) begin
                bus.ifu_req_valid = 1'b1;
                bus.ifu_req_pc    = 32'h8000_0000 + 32'(k * 4);
                #1;
                checks++; if (bus.ifu_req_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got=%b want=1", k, bus.ifu_req_ready); end
            end else begin
                bus.ifu_req_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++; if (bus.ifu_rsp_valid !== 1'b0) begin errors++; $display("FAIL stream_idle got=%b want=0", bus.ifu_rsp_valid); end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        bus.ifu_rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++; if (bus.ifu_rsp_valid !== 1'b1 || bus.ifu_rsp_instr !== 32'h1111_1111)
                    begin errors++; $display("FAIL bp_hold[%0d] got=%b/%h want=1/11111111", k, bus.ifu_rsp_valid, bus.ifu_rsp_instr); end
            end
            bus.ifu_req_valid = 1'b1;
            bus.ifu_req_pc    = 32'h8000_0000 + 32'(acc * 4);
            #1;
            checks++; if (bus.ifu_req_ready !== (k < 2)) begin errors++; $display("FAIL bp_ready[%0d] got=%b want=%b", k, bus.ifu_req_ready, (k < 2)); end
            if (bus.ifu_req_ready === 1'b1) acc++;
        end
        checks++; if (acc != 2) begin errors++; $display("FAIL bp_accepted got=%0d want=2", acc); end
        @(negedge clk);
        checks++; if (bus.ifu_rsp_valid !== 1'b1 || bus.ifu_rsp_instr !== 32'h1111_1111)
            begin errors++; $display("FAIL bp_first got=%b/%h want=1/11111111", bus.ifu_rsp_valid, bus.ifu_rsp_instr); end
        bus.ifu_req_valid = 1'b0;
        bus.ifu_rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.ifu_rsp_valid !== 1'b1 || bus.ifu_rsp_instr !== 32'h2222_2222)
            begin errors++; $display("FAIL bp_second got=%b/%h want=1/22222222", bus.ifu_rsp_valid, bus.ifu_rsp_instr); end
        checks++; if (bus.ifu_req_ready !== 1'b1) begin errors++; $display("FAIL bp_reassert got=%b want=1", bus.ifu_req_ready); end
        @(negedge clk);
        checks++; if (bus.ifu_rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got=%b want=0", bus.ifu_rsp_valid); end
    endtask

    task automatic test_miss();
        logic [31:0] pcs   [4] = '{32'h8000_4000, 32'h7FFF_FFFC, 32'h8000_0002, 32'h8000_3FFC};
        logic [31:0] e_ins [4] = '{32'h0000_0013, 32'h0000_0013, 32'h0000_0013, 32'hA5A5_0FFF};
        logic        e_err [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        bus.ifu_rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++; if (bus.ifu_rsp_valid !== 1'b1 || bus.ifu_rsp_err !== e_err[k-1] || bus.ifu_rsp_instr !== e_ins[k-1])
                    begin errors++; $display("FAIL miss[%0d] got=%b/%b/%h want=1/%b/%h", k-1, bus.ifu_rsp_valid, bus.ifu_rsp_err, bus.ifu_rsp_instr, e_err[k-1], e_ins[k-1]); end
            end
            if (k < 4) begin
                bus.ifu_req_valid = 1'b1;
                bus.ifu_req_pc    = pcs[k];
                #1;
                checks++; if (bus.ifu_req_ready !== 1'b1) begin errors++; $display("FAIL miss_ready[%0d] got=%b want=1", k, bus.ifu_req_ready); end
            end else begin
                bus.ifu_req_valid = 1'b0;
            end
        end
    endtask

    task automatic test_load_priority();
        bus.ifu_rsp_ready = 1'b1;
        @(negedge clk);
        bus.load_valid    = 1'b1;
        bus.load_addr     = 12'h005;
        bus.load_data     = 32'hDEAD_BEEF;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_pc    = 32'h8000_0014;
        #1;
        checks++; if (bus.ifu_req_ready !== 1'b0) begin errors++; $display("FAIL load_blocks_ready got=%b want=0", bus.ifu_req_ready); end
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL load_ready got=%b want=1", bus.load_ready); end
        @(negedge clk);
        bus.load_valid = 1'b0;
        #1;
        checks++; if (bus.ifu_req_ready !== 1'b1) begin errors++; $display("FAIL load_after_ready got=%b want=1", bus.ifu_req_ready); end
        checks++; if (bus.ifu_rsp_valid !== 1'b0) begin errors++; $display("FAIL load_no_rsp got=%b want=0", bus.ifu_rsp_valid); end
        @(negedge clk);
        bus.ifu_req_valid = 1'b0;
        checks++; if (bus.ifu_rsp_valid !== 1'b1 || bus.ifu_rsp_err !== 1'b0 || bus.ifu_rsp_instr !== 32'hDEAD_BEEF)
            begin errors++; $display("FAIL load_readback got=%b/%b/%h want=1/0/deadbeef", bus.ifu_rsp_valid, bus.ifu_rsp_err, bus.ifu_rsp_instr); end
    endtask

    task automatic test_reset_midstream();
        bus.ifu_rsp_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.ifu_req_valid = 1'b1;
            bus.ifu_req_pc    = 32'h8000_0000 + 32'(k * 4);
        end
        @(negedge clk);
        bus.ifu_req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.ifu_rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b want=0", bus.ifu_rsp_valid); end
        checks++; if (bus.ifu_req_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%b want=0", bus.ifu_req_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.ifu_rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (bus.ifu_rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale[%0d] got=%b want=0", k, bus.ifu_rsp_valid); end
        end
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_pc    = 32'h8000_0000;
        #1;
        checks++; if (bus.ifu_req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_back got=%b want=1", bus.ifu_req_ready); end
        @(negedge clk);
        bus.ifu_req_valid = 1'b0;
        checks++; if (bus.ifu_rsp_valid !== 1'b1 || bus.ifu_rsp_instr !== 32'h1111_1111)
            begin errors++; $display("FAIL midrst_fetch got=%b/%h want=1/11111111", bus.ifu_rsp_valid, bus.ifu_rsp_instr); end
    endtask

    task automatic test_random();
        logic [31:0] pcs  [8] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C,
                                  32'h8000_0014, 32'h8000_3FFC, 32'h8000_4000, 32'h8000_0001};
        logic [32:0] expv [8] = '{{1'b0, 32'h1111_1111}, {1'b0, 32'h2222_2222}, {1'b0, 32'h3333_3333},
                                  {1'b0, 32'h4444_4444}, {1'b0, 32'hDEAD_BEEF}, {1'b0, 32'hA5A5_0FFF},
                                  {1'b1, 32'h0000_0013}, {1'b1, 32'h0000_0013}};
        logic [32:0] q [$];
        logic [32:0] head;
        logic        prev_hold = 1'b0;
        logic [32:0] prev_data = 33'h0;
        int          sel;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            if (prev_hold) begin
                checks++; if (bus.ifu_rsp_valid !== 1'b1 || {bus.ifu_rsp_err, bus.ifu_rsp_instr} !== prev_data)
                    begin errors++; $display("FAIL rnd_stable[%0d] got=%b/%h want=1/%h", cyc, bus.ifu_rsp_valid, {bus.ifu_rsp_err, bus.ifu_rsp_instr}, prev_data); end
            end
            sel = int'($urandom_range(0, 7));
            bus.ifu_rsp_ready = ($urandom_range(0, 3) != 0);
            bus.ifu_req_valid = ($urandom_range(0, 1) != 0);
            bus.ifu_req_pc    = pcs[sel];
            #1;
            if (bus.ifu_rsp_valid === 1'b1 && bus.ifu_rsp_ready === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rnd_extra[%0d] got=%h want=none", cyc, {bus.ifu_rsp_err, bus.ifu_rsp_instr});
                end else begin
                    head = q.pop_front();
                    if ({bus.ifu_rsp_err, bus.ifu_rsp_instr} !== head) begin
                        errors++; $display("FAIL rnd_data[%0d] got=%h want=%h", cyc, {bus.ifu_rsp_err, bus.ifu_rsp_instr}, head);
                    end
                end
            end
            prev_hold = (bus.ifu_rsp_valid === 1'b1) && (bus.ifu_rsp_ready === 1'b0);
            prev_data = {bus.ifu_rsp_err, bus.ifu_rsp_instr};
            if (bus.ifu_req_valid === 1'b1 && bus.ifu_req_ready === 1'b1) begin
                q.push_back(expv[sel]);
                checks++; if (q.size() > 2) begin errors++; $display("FAIL rnd_credit[%0d] got=%0d want<=2", cyc, q.size()); end
            end
        end
        bus.ifu_req_valid = 1'b0;
        bus.ifu_rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.ifu_rsp_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rnd_drain_extra got=%h want=none", {bus.ifu_rsp_err, bus.ifu_rsp_instr});
                end else begin
                    head = q.pop_front();
                    if ({bus.ifu_rsp_err, bus.ifu_rsp_instr} !== head) begin
                        errors++; $display("FAIL rnd_drain_data got=%h want=%h", {bus.ifu_rsp_err, bus.ifu_rsp_instr}, head);
                    end
                end
            end
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_lost got=%0d want=0 pending", q.size()); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_miss();
        test_load_priority();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ifu_itcm_rsp.md
Name: ifu_itcm_rsp

Overview:
- Responder end of the IFU fetch interface: accepts PC requests over the req valid/ready channel and returns one 32-bit instruction per request over the rsp valid/ready channel.
- Holds a single-port, word-addressed ITCM instruction array with one-cycle synchronous read.
- A 2-entry response FIFO absorbs backpressure.
- A side write port loads program images and has priority over fetch.

Parameters:
- PC_SIZE, 32, width of request PC.
- INSTR_SIZE, 32, instruction/word width.
- ITCM_AW, 12, word-address width; array holds 2^ITCM_AW words (16 KiB at default).
- ITCM_BASE, 32'h8000_0000, byte base address of ITCM; must be aligned to 4*2^ITCM_AW.
- RSP_DEPTH, 2, response FIFO depth (credit limit for outstanding requests).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ifu_req_valid  in  1  fetch request valid.
- ifu_req_ready  out  1  request accepted when high together with valid.
- ifu_req_pc  in  PC_SIZE  byte address of instruction.
- ifu_rsp_valid  out  1  response valid.
- ifu_rsp_ready  in  1  IFU accepts response.
- ifu_rsp_instr  out  INSTR_SIZE  fetched instruction.
- ifu_rsp_err  out  1  request was out of range or misaligned.
- load_valid  in  1  program-load write strobe.
- load_ready  out  1  always 1 outside reset.
- load_addr  in  ITCM_AW  word index to write.
- load_data  in  INSTR_SIZE  word to write.

Behaviour:
- Reset (async, rst_n low): ifu_req_ready=0, ifu_rsp_valid=0, ifu_rsp_err=0, ifu_rsp_instr=0, load_ready=0. The FIFO is emptied and any in-flight read is dropped. Array contents are not reset.
- Reset release: ifu_req_ready and load_ready go to 1 on the first clk edge after rst_n rises.
- Credit rule: ifu_req_ready = ~load_valid & (fifo_cnt + inflight < RSP_DEPTH), where inflight = 1 if a request was accepted in the previous cycle.
  - Same-cycle credit return is not used.
  - Back-to-back requests with ifu_rsp_ready=1 sustain one request per cycle.
- Request handshake (cycle T): decode ifu_req_pc.
  - hit: (pc - ITCM_BASE) < 4*2^ITCM_AW and pc[1:0]==0. Array read at word index (pc - ITCM_BASE)[ITCM_AW+1:2].
  - miss: no array access; the response carries err=1 and instr = 32'h0000_0013 (NOP).
- Latency: response data is available in T+1.
  - If the FIFO is empty, the response bypasses the FIFO: ifu_rsp_valid=1 in T+1 with data direct from the array.
  - If it is not consumed in T+1, it is written into the FIFO tail at the end of T+1.
  - If the FIFO is non-empty, the new data is pushed behind the existing entries; responses are strictly in order.
- Output: ifu_rsp_valid = (fifo_cnt != 0) | inflight. Data and err come from the FIFO head when fifo_cnt != 0, otherwise from the bypass path.
  - rsp_valid/instr/err must remain stable while valid & ~ready.
- FIFO: 2 entries of {err, instr}, with wr/rd pointers of 1 bit each plus a count of 0..2.
  - Simultaneous push and pop keeps the count unchanged.
  - Push when full cannot occur, because the credit rule forbids it. The verification bench asserts this.
- Load port: when load_valid=1 the array is written at load_addr on that edge, and fetch is blocked (req_ready=0) for that cycle.
  - A read of the same word on the following cycle returns the new data.
  - Load and an in-flight read's data return do not conflict: the read was already issued in the prior cycle.
- Pointer wrap: FIFO pointers wrap modulo RSP_DEPTH. The PC offset is computed modulo 2^PC_SIZE; a PC below ITCM_BASE wraps to a large offset and is a miss.
- Arithmetic: offset = ifu_req_pc - ITCM_BASE, PC_SIZE bits, unsigned.

Test Plan:
- Load words 0..3 = 11111111, 22222222, 33333333, 44444444 via load port; rsp_ready=1; requests 80000000, 80000004, 80000008, 8000000C on 4 consecutive cycles -> req_ready held 1; rsp_valid 1 on cycles T+1..T+4 with data in order; err=0.
- Hold rsp_ready=0 and issue requests every cycle -> exactly 2 accepted, then req_ready=0; data stable. Raise rsp_ready -> both responses delivered in order and req_ready reasserts.
- Request 80004000 (just past end), 7FFFFFFC, and 80000002 -> each response err=1, instr=00000013, one cycle after the handshake.
- load_valid=1 together with req_valid=1 to word 5 = DEADBEEF -> req_ready=0 that cycle; next cycle the request is accepted and returns DEADBEEF.
- Two requests outstanding (rsp_ready=0), drop rst_n mid-stream -> rsp_valid and req_ready go 0 immediately (async). After release, no stale response appears, and a fresh fetch of word 0 returns 11111111.
- Random valid/ready toggling over 10k cycles against a scoreboard -> in-order, no loss, no duplication; FIFO never pushed when full.
